// File: rtl/rv32v_types_pkg.sv
// Shared types for the RV32V vector memory stage: element widths, FSM states,
// latched op / writeback packet structs and byte-enable helpers.
package rv32v_types_pkg;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2
  } sew_t;

  typedef logic [4:0] offset_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LANE0 = 2'd1,
    LANE1 = 2'd2,
    RESP  = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic        load;
    logic        store;
    logic [31:0] sdata0;
    logic [31:0] sdata1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic        wen0;
    logic        wen1;
    offset_t     woff0;
    offset_t     woff1;
    logic        cfg;
    logic [7:0]  vtype;
    logic [31:0] vl;
    sew_t        eew;
    logic [4:0]  vd;
    logic        sbw;
  } mem_op_t;

  typedef struct packed {
    logic        valid;
    logic        wen0;
    logic        wen1;
    logic [31:0] wdat0;
    logic [31:0] wdat1;
    offset_t     woff0;
    offset_t     woff1;
    logic [4:0]  vd;
    logic        sbw;
    logic        cfg;
    logic [31:0] vl;
    logic [7:0]  vtype;
    logic        mis;
  } wb_pkt_t;

  // Byte lanes touched by one element; misaligned SEW16/SEW32 results are never issued.
  function automatic logic [3:0] byten_gen(input sew_t eew, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (eew)
      SEW8:    be = 4'b0001 << addr_lo;
      SEW16:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/rv32v_mem_lane_align.sv
// Per-lane alignment helper: byte enables, store-data replication, load
// extraction (zero-extended) and misalignment detection. Purely combinational.
module rv32v_mem_lane_align
  import rv32v_types_pkg::*;
(
  input  sew_t        eew,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  byten,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  always_comb begin
    byten      = byten_gen(eew, addr_lo);
    wdata      = store_data;
    load_data  = rdata;
    misaligned = 1'b0;
    case (eew)
      SEW8: begin
        wdata     = {4{store_data[7:0]}};
        load_data = {24'b0, rdata[{addr_lo, 3'b000} +: 8]};
      end
      SEW16: begin
        wdata      = {2{store_data[15:0]}};
        load_data  = {16'b0, (addr_lo[1] ? rdata[31:16] : rdata[15:0])};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/rv32v_memory_unit.sv
// Vector memory stage: serialises lane 0 / lane 1 element accesses onto one
// data-memory port and emits one registered writeback packet per op.
// Optional RV32V_MEM_LANE_MERGE_EN: same-word aligned lanes share one access.
module rv32v_memory_unit
  import rv32v_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              store,
  input  logic [DATA_W-1:0] storedata0,
  input  logic [DATA_W-1:0] storedata1,
  input  logic [31:0]       aluresult0,
  input  logic [31:0]       aluresult1,
  input  logic              wen0,
  input  logic              wen1,
  input  offset_t           woffset0,
  input  offset_t           woffset1,
  input  logic              config_type,
  input  logic [7:0]        vtype,
  input  logic [31:0]       vl,
  input  sew_t              eew,
  input  logic [4:0]        vd,
  input  logic              single_bit_write,
  output logic              busy,
  output logic              dmem_ren,
  output logic              dmem_wen,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_byten,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_busy,
  output logic              wb_valid,
  output logic              wb_wen0,
  output logic              wb_wen1,
  output logic [DATA_W-1:0] wb_wdat0,
  output logic [DATA_W-1:0] wb_wdat1,
  output offset_t           wb_woffset0,
  output offset_t           wb_woffset1,
  output logic [4:0]        wb_vd,
  output logic              wb_single_bit_write,
  output logic              wb_config_type,
  output logic [31:0]       wb_vl,
  output logic [7:0]        wb_vtype,
  output logic              misaligned
);

  mem_state_t  state_q, state_d;
  mem_op_t     op_q, op_d, op_in;
  logic [31:0] ldata0_q, ldata0_d, ldata1_q, ldata1_d;
  logic        mis_q, mis_d;
  wb_pkt_t     wb_q, wb_d;

  logic        ready, in_lane, lane_sel;
  logic [31:0] lane_addr, lane_sdata, lane_wd, lane_ld;
  logic [3:0]  lane_be;
  logic        lane_mis;
  logic        merge;
  logic [3:0]  req_byten;
  logic [31:0] req_wdata, merge_ld1;

  always_comb begin
    op_in        = '0;
    op_in.load   = load;
    op_in.store  = store;
    op_in.sdata0 = storedata0;
    op_in.sdata1 = storedata1;
    op_in.addr0  = aluresult0;
    op_in.addr1  = aluresult1;
    op_in.wen0   = wen0;
    op_in.wen1   = wen1;
    op_in.woff0  = woffset0;
    op_in.woff1  = woffset1;
    op_in.cfg    = config_type;
    op_in.vtype  = vtype;
    op_in.vl     = vl;
    op_in.eew    = eew;
    op_in.vd     = vd;
    op_in.sbw    = single_bit_write;
  end

  // RESP already has busy low, so it accepts a new op exactly like IDLE.
  assign ready      = (state_q == IDLE) || (state_q == RESP);
  assign in_lane    = (state_q == LANE0) || (state_q == LANE1);
  assign lane_sel   = (state_q == LANE1);
  assign lane_addr  = lane_sel ? op_q.addr1  : op_q.addr0;
  assign lane_sdata = lane_sel ? op_q.sdata1 : op_q.sdata0;

  rv32v_mem_lane_align u_align (
    .eew        (op_q.eew),
    .addr_lo    (lane_addr[1:0]),
    .store_data (lane_sdata),
    .rdata      (dmem_rdata),
    .byten      (lane_be),
    .wdata      (lane_wd),
    .load_data  (lane_ld),
    .misaligned (lane_mis)
  );

`ifdef RV32V_MEM_LANE_MERGE_EN
  logic [3:0]  be1;
  logic [31:0] wd1, ld1;
  logic        mis1;

  rv32v_mem_lane_align u_align_lane1 (
    .eew        (op_q.eew),
    .addr_lo    (op_q.addr1[1:0]),
    .store_data (op_q.sdata1),
    .rdata      (dmem_rdata),
    .byten      (be1),
    .wdata      (wd1),
    .load_data  (ld1),
    .misaligned (mis1)
  );

  assign merge     = (state_q == LANE0) && op_q.wen0 && op_q.wen1 && !lane_mis && !mis1 &&
                     (op_q.addr0[31:2] == op_q.addr1[31:2]);
  assign req_byten = merge ? (lane_be | be1) : lane_be;
  assign req_wdata = merge ? ((lane_wd & byte_mask(lane_be)) | (wd1 & byte_mask(be1))) : lane_wd;
  assign merge_ld1 = ld1;
`else
  assign merge     = 1'b0;
  assign req_byten = lane_be;
  assign req_wdata = lane_wd;
  assign merge_ld1 = '0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      op_q     <= '0;
      ldata0_q <= '0;
      ldata1_q <= '0;
      mis_q    <= 1'b0;
      wb_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ldata0_q <= ldata0_d;
      ldata1_q <= ldata1_d;
      mis_q    <= mis_d;
      wb_q     <= wb_d;
    end
  end

  // A misaligned lane burns one cycle without a request and loses its write enable.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ldata0_d = ldata0_q;
    ldata1_d = ldata1_q;
    mis_d    = mis_q;
    case (state_q)
      LANE0: begin
        if (lane_mis) begin
          op_d.wen0 = 1'b0;
          mis_d     = 1'b1;
          state_d   = op_q.wen1 ? LANE1 : RESP;
        end else if (!dmem_busy) begin
          if (op_q.load) ldata0_d = lane_ld;
          if (merge) begin
            if (op_q.load) ldata1_d = merge_ld1;
            state_d = RESP;
          end else begin
            state_d = op_q.wen1 ? LANE1 : RESP;
          end
        end
      end
      LANE1: begin
        if (lane_mis) begin
          op_d.wen1 = 1'b0;
          mis_d     = 1'b1;
          state_d   = RESP;
        end else if (!dmem_busy) begin
          if (op_q.load) ldata1_d = lane_ld;
          state_d = RESP;
        end
      end
      default: begin
        if (load || store) begin
          op_d     = op_in;
          ldata0_d = '0;
          ldata1_d = '0;
          mis_d    = 1'b0;
          state_d  = wen0 ? LANE0 : (wen1 ? LANE1 : RESP);
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Packet is built from next-state values so it is valid during the RESP cycle itself.
  always_comb begin
    wb_d       = wb_q;
    wb_d.valid = 1'b0;
    if (state_d == RESP) begin
      wb_d.valid = 1'b1;
      wb_d.wen0  = op_d.load & op_d.wen0;
      wb_d.wen1  = op_d.load & op_d.wen1;
      wb_d.wdat0 = ldata0_d;
      wb_d.wdat1 = ldata1_d;
      wb_d.woff0 = op_d.woff0;
      wb_d.woff1 = op_d.woff1;
      wb_d.vd    = op_d.vd;
      wb_d.sbw   = op_d.sbw;
      wb_d.cfg   = op_d.cfg;
      wb_d.vl    = op_d.vl;
      wb_d.vtype = op_d.vtype;
      wb_d.mis   = mis_d;
    end else if (ready && !load && !store) begin
      wb_d.valid = wen0 | wen1 | config_type;
      wb_d.wen0  = wen0;
      wb_d.wen1  = wen1;
      wb_d.wdat0 = aluresult0;
      wb_d.wdat1 = aluresult1;
      wb_d.woff0 = woffset0;
      wb_d.woff1 = woffset1;
      wb_d.vd    = vd;
      wb_d.sbw   = single_bit_write;
      wb_d.cfg   = config_type;
      wb_d.vl    = vl;
      wb_d.vtype = vtype;
      wb_d.mis   = 1'b0;
    end
  end

  always_comb begin
    busy       = in_lane;
    dmem_ren   = 1'b0;
    dmem_wen   = 1'b0;
    dmem_addr  = '0;
    dmem_byten = 4'b0000;
    dmem_wdata = '0;
    if (in_lane && !lane_mis) begin
      dmem_ren   = op_q.load;
      dmem_wen   = op_q.store;
      dmem_addr  = {lane_addr[ADDR_W-1:2], 2'b00};
      dmem_byten = req_byten;
      dmem_wdata = req_wdata;
    end
  end

  assign wb_valid            = wb_q.valid;
  assign wb_wen0             = wb_q.wen0;
  assign wb_wen1             = wb_q.wen1;
  assign wb_wdat0            = wb_q.wdat0;
  assign wb_wdat1            = wb_q.wdat1;
  assign wb_woffset0         = wb_q.woff0;
  assign wb_woffset1         = wb_q.woff1;
  assign wb_vd               = wb_q.vd;
  assign wb_single_bit_write = wb_q.sbw;
  assign wb_config_type      = wb_q.cfg;
  assign wb_vl               = wb_q.vl;
  assign wb_vtype            = wb_q.vtype;
  assign misaligned          = wb_q.mis;

endmodule

// File: tb/tb_rv32v_memory_unit.sv
// Randomised self-checking bench for rv32v_memory_unit with a word-array
// memory model and an element-level reference for accesses and packets.
module tb_rv32v_memory_unit;
  import rv32v_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        load, store;
  logic [31:0] storedata0, storedata1, aluresult0, aluresult1;
  logic        wen0, wen1;
  offset_t     woffset0, woffset1;
  logic        config_type;
  logic [7:0]  vtype;
  logic [31:0] vl;
  sew_t        eew;
  logic [4:0]  vd;
  logic        single_bit_write;
  logic        busy, dmem_ren, dmem_wen;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_byten;
  logic        dmem_busy;
  logic        wb_valid, wb_wen0, wb_wen1;
  logic [31:0] wb_wdat0, wb_wdat1;
  offset_t     wb_woffset0, wb_woffset1;
  logic [4:0]  wb_vd;
  logic        wb_single_bit_write, wb_config_type;
  logic [31:0] wb_vl;
  logic [7:0]  wb_vtype;
  logic        misaligned;

  logic [31:0] mem [0:63];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;

  rv32v_memory_unit dut (
    .CLK(CLK), .RST(RST), .load(load), .store(store),
    .storedata0(storedata0), .storedata1(storedata1),
    .aluresult0(aluresult0), .aluresult1(aluresult1),
    .wen0(wen0), .wen1(wen1), .woffset0(woffset0), .woffset1(woffset1),
    .config_type(config_type), .vtype(vtype), .vl(vl), .eew(eew), .vd(vd),
    .single_bit_write(single_bit_write), .busy(busy),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_byten(dmem_byten), .dmem_rdata(dmem_rdata),
    .dmem_busy(dmem_busy), .wb_valid(wb_valid), .wb_wen0(wb_wen0), .wb_wen1(wb_wen1),
    .wb_wdat0(wb_wdat0), .wb_wdat1(wb_wdat1), .wb_woffset0(wb_woffset0),
    .wb_woffset1(wb_woffset1), .wb_vd(wb_vd), .wb_single_bit_write(wb_single_bit_write),
    .wb_config_type(wb_config_type), .wb_vl(wb_vl), .wb_vtype(wb_vtype),
    .misaligned(misaligned)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] mask_of(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (be[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  task automatic idleInputs();
    load = 0; store = 0; wen0 = 0; wen1 = 0; config_type = 0;
    storedata0 = '0; storedata1 = '0; aluresult0 = '0; aluresult1 = '0;
    woffset0 = '0; woffset1 = '0; vtype = '0; vl = '0; eew = SEW8; vd = '0;
    single_bit_write = 0;
  endtask

  // stall_mode: 0 random stalls, 1 never stall, 2 stall the first request 3 cycles
  task automatic applyStimulus(input bit ld, input bit st, input sew_t sew,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] sd0, input logic [31:0] sd1,
                               input bit w0, input bit w1, input bit cfg,
                               input logic [31:0] vl_v, input logic [7:0] vt,
                               input int stall_mode);
    int          size, lo, visits, cyc, req_idx, stalls, cur_stall;
    bit          act[2], algn[2], merged, got, stl, exp_wen[2], exp_mis;
    logic [31:0] addr_n[2], sd_n[2], lval[2], placed[2], emask;
    logic [3:0]  be[2];
    logic [31:0] exp_addr[$], exp_wd[$];
    logic [3:0]  exp_be[$];
    offset_t     o0, o1;
    logic [4:0]  vd_v;
    bit          sbw_v;

    o0 = offset_t'($urandom); o1 = offset_t'($urandom);
    vd_v = 5'($urandom); sbw_v = 1'($urandom);
    load = ld; store = st; eew = sew; aluresult0 = a0; aluresult1 = a1;
    storedata0 = sd0; storedata1 = sd1; wen0 = w0; wen1 = w1; config_type = cfg;
    vl = vl_v; vtype = vt; woffset0 = o0; woffset1 = o1; vd = vd_v; single_bit_write = sbw_v;

    if (!ld && !st) begin
      @(posedge CLK); #1;
      checkOutput("nm_busy", busy, 0);
      checkOutput("nm_valid", wb_valid, w0 | w1 | cfg);
      checkOutput("nm_wen0", wb_wen0, w0);
      checkOutput("nm_wen1", wb_wen1, w1);
      checkOutput("nm_wdat0", wb_wdat0, a0);
      checkOutput("nm_wdat1", wb_wdat1, a1);
      checkOutput("nm_vl", wb_vl, vl_v);
      checkOutput("nm_vtype", wb_vtype, vt);
      checkOutput("nm_cfg", wb_config_type, cfg);
      checkOutput("nm_vd", wb_vd, vd_v);
      checkOutput("nm_mis", misaligned, 0);
      checkOutput("nm_req", {dmem_ren, dmem_wen}, 0);
      idleInputs();
    end else begin
      size  = (sew == SEW8) ? 1 : ((sew == SEW16) ? 2 : 4);
      emask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
      addr_n[0] = a0; addr_n[1] = a1; sd_n[0] = sd0; sd_n[1] = sd1;
      act[0] = w0; act[1] = w1;
      for (int n = 0; n < 2; n++) begin
        lo        = int'(addr_n[n] & 32'd3);
        algn[n]   = (addr_n[n] % size) == 0;
        be[n]     = ((size == 1) ? 4'b0001 : ((size == 2) ? 4'b0011 : 4'b1111)) << lo;
        lval[n]   = (mem[(addr_n[n] >> 2) & 63] >> (8 * lo)) & emask;
        placed[n] = (sd_n[n] & emask) << (8 * lo);
        exp_wen[n] = ld && act[n] && algn[n];
      end
      exp_mis = (act[0] && !algn[0]) || (act[1] && !algn[1]);
      merged  = 0;
`ifdef RV32V_MEM_LANE_MERGE_EN
      merged = act[0] && act[1] && algn[0] && algn[1] && ((a0 >> 2) == (a1 >> 2));
`endif
      if (merged) begin
        exp_addr.push_back(a0 & ~32'd3);
        exp_be.push_back(be[0] | be[1]);
        exp_wd.push_back(placed[0] | placed[1]);
        visits = 1;
      end else begin
        visits = 0;
        for (int n = 0; n < 2; n++) begin
          if (act[n]) visits++;
          if (act[n] && algn[n]) begin
            exp_addr.push_back(addr_n[n] & ~32'd3);
            exp_be.push_back(be[n]);
            exp_wd.push_back(placed[n]);
          end
        end
      end

      @(posedge CLK); #1;
      idleInputs();
      cyc = 0; req_idx = 0; stalls = 0; cur_stall = 0; got = 0;
      while (!got && cyc < 60) begin
        if (wb_valid) begin
          got = 1;
          checkOutput("wb_busy", busy, 0);
          checkOutput("wb_latency", cyc, visits + stalls);
          checkOutput("wb_wen0", wb_wen0, exp_wen[0]);
          checkOutput("wb_wen1", wb_wen1, exp_wen[1]);
          if (exp_wen[0]) checkOutput("wb_wdat0", wb_wdat0, lval[0]);
          if (exp_wen[1]) checkOutput("wb_wdat1", wb_wdat1, lval[1]);
          checkOutput("wb_mis", misaligned, exp_mis);
          checkOutput("wb_off0", wb_woffset0, o0);
          checkOutput("wb_off1", wb_woffset1, o1);
          checkOutput("wb_vd", wb_vd, vd_v);
          checkOutput("wb_sbw", wb_single_bit_write, sbw_v);
          checkOutput("wb_vl", wb_vl, vl_v);
          checkOutput("wb_vtype", wb_vtype, vt);
        end else begin
          if (dmem_ren || dmem_wen) begin
            checkOutput("req_busy", busy, 1);
            if (req_idx < exp_addr.size()) begin
              checkOutput("req_kind", {dmem_ren, dmem_wen}, {ld, st});
              checkOutput("req_addr", dmem_addr, exp_addr[req_idx]);
              checkOutput("req_byten", dmem_byten, exp_be[req_idx]);
              if (st) checkOutput("req_wdata", dmem_wdata & mask_of(exp_be[req_idx]), exp_wd[req_idx]);
            end else begin
              checkOutput("extra_req", {dmem_ren, dmem_wen}, 0);
            end
            if (stall_mode == 1) stl = 0;
            else if (stall_mode == 2) stl = (req_idx == 0) && (cur_stall < 3);
            else stl = (cur_stall < 3) && ($urandom_range(0, 2) == 0);
            dmem_busy  = stl;
            dmem_rdata = stl ? $urandom : mem[(dmem_addr >> 2) & 63];
            if (stl) begin
              stalls++; cur_stall++;
            end else begin
              if (st && req_idx < exp_addr.size())
                mem[(exp_addr[req_idx] >> 2) & 63] = (mem[(exp_addr[req_idx] >> 2) & 63] & ~mask_of(exp_be[req_idx]))
                                                     | exp_wd[req_idx];
              req_idx++; cur_stall = 0;
            end
          end else begin
            dmem_busy  = 1'($urandom);
            dmem_rdata = $urandom;
          end
          @(posedge CLK); #1;
          cyc++;
        end
      end
      if (!got) checkOutput("wb_timeout", wb_valid, 1);
      checkOutput("req_count", req_idx, exp_addr.size());
      dmem_busy = 0;
    end
  endtask

  task automatic resetMidAccess();
    load = 1; eew = SEW32; aluresult0 = 32'h10; aluresult1 = 32'h14; wen0 = 1; wen1 = 1;
    @(posedge CLK); #1;
    idleInputs();
    dmem_busy = 0; dmem_rdata = mem[4];
    @(posedge CLK); #1;
    checkOutput("rst_pre_ren", dmem_ren, 1);
    checkOutput("rst_pre_addr", dmem_addr, 32'h14);
    dmem_busy = 1;
    #2 RST = 1;
    #1;
    checkOutput("rst_ren", dmem_ren, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_byten", dmem_byten, 0);
    checkOutput("rst_addr", dmem_addr, 0);
    checkOutput("rst_wb", wb_valid, 0);
    @(posedge CLK); #1;
    RST = 0; dmem_busy = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      checkOutput("rst_no_wb", wb_valid, 0);
      checkOutput("rst_idle", busy, 0);
    end
  endtask

  initial begin
    bit          ld, st, w0, w1;
    int          kind;
    logic [31:0] a0, a1;
    RST = 1; dmem_busy = 0; dmem_rdata = '0;
    idleInputs();
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_req", {dmem_ren, dmem_wen}, 0);
    checkOutput("reset_wb_valid", wb_valid, 0);
    checkOutput("reset_mis", misaligned, 0);
    checkOutput("reset_wb_vl", wb_vl, 0);
    RST = 0;
    @(posedge CLK); #1;

    mem[0] = 32'hAABBCCDD; mem[1] = 32'h11223344;
    applyStimulus(1, 0, SEW32, 32'h100, 32'h104, 0, 0, 1, 1, 0, 32'd4, 8'h0, 1);
    applyStimulus(0, 1, SEW8, 32'h203, 32'h0, 32'h5A, 0, 1, 0, 0, 32'd4, 8'h0, 1);
    applyStimulus(1, 0, SEW16, 32'h301, 32'h0, 0, 0, 1, 0, 0, 32'd4, 8'h0, 1);
    applyStimulus(1, 0, SEW32, 32'h20, 32'h24, 0, 0, 1, 1, 0, 32'd2, 8'h0, 2);
    applyStimulus(0, 0, SEW8, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'd8, 8'h10, 1);
    applyStimulus(1, 0, SEW16, 32'h400, 32'h402, 0, 0, 1, 1, 0, 32'd2, 8'h0, 1);
    applyStimulus(0, 1, SEW16, 32'h40, 32'h42, 32'h1234, 32'h5678, 1, 1, 0, 32'd2, 8'h0, 1);
    applyStimulus(0, 1, SEW32, 32'h50, 32'h60, 0, 0, 0, 0, 0, 32'd0, 8'h0, 1);

    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 4);
      ld = (kind <= 1); st = (kind == 2) || (kind == 3);
      a0 = $urandom_range(0, 255);
      a1 = ($urandom_range(0, 1) == 1) ? ((a0 & 32'hFC) | $urandom_range(0, 3)) : $urandom_range(0, 255);
      w0 = ($urandom_range(0, 3) != 0);
      w1 = ($urandom_range(0, 3) != 0);
      applyStimulus(ld, st, sew_t'($urandom_range(0, 2)), a0, a1, $urandom, $urandom,
                    w0, w1, 1'($urandom), $urandom_range(0, 64), 8'($urandom), 0);
    end

    resetMidAccess();
    applyStimulus(1, 0, SEW8, 32'h33, 32'h35, 0, 0, 1, 1, 0, 32'd2, 8'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
